// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed 7-segment scan controller.
// Each digit owns the shared segment bus for DIV cycles, the first BLANK of
// which keep every common off to avoid ghosting. New contents are staged in
// pending registers and copied to the shadow only at a frame boundary, so a
// frame is never torn. Outputs are registered from next-state values, so in
// every cycle COM/segments/dp match that cycle's cnt, idx and shadow exactly.
module seg_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  VALID,
  input  logic [7:0]  DP,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [7:0]  COM,
  output logic        ACK,
  output logic        FRAME
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_end;

  // Pending (staged) and shadow (displayed) contents
  logic          pend_q, pend_d;
  logic [31:0]   pend_dig_q, pend_dig_d;
  logic [7:0]    pend_val_q, pend_val_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic [31:0]   shd_dig_q, shd_dig_d;
  logic [7:0]    shd_val_q, shd_val_d;
  logic [7:0]    shd_dp_q, shd_dp_d;
  logic          commit;

  // Registered outputs
  logic [7:0]    com_q, com_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ack_q;
  logic          frame_q, frame_d;

  // Per-digit views of the next shadow, selected by the next digit index
  logic [3:0]    code_arr [8];
  logic [7:0]    digit_onehot;
  logic [3:0]    sel_code;
  logic          sel_valid;
  logic          sel_dp;
  logic          blank_d;

  // Segment pattern {a,b,c,d,e,f,g} for a hexadecimal digit code
  function automatic logic [6:0] decode_hex(input logic [3:0] code);
    logic [6:0] s;
    s = 7'h00;
    case (code)
      4'h0: s = 7'h7E;  // abcdef
      4'h1: s = 7'h30;  // bc
      4'h2: s = 7'h6D;  // abdeg
      4'h3: s = 7'h79;  // abcdg
      4'h4: s = 7'h33;  // bcfg
      4'h5: s = 7'h5B;  // acdfg
      4'h6: s = 7'h5F;  // acdefg
      4'h7: s = 7'h70;  // abc
      4'h8: s = 7'h7F;  // abcdefg
      4'h9: s = 7'h7B;  // abcdfg
      4'hA: s = 7'h77;  // abcefg
      4'hB: s = 7'h1F;  // cdefg
      4'hC: s = 7'h4E;  // adef
      4'hD: s = 7'h3D;  // bcdeg
      4'hE: s = 7'h4F;  // adefg
      4'hF: s = 7'h47;  // aefg
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Last cycle of digit 7's slot while scanning: the only safe update point
  assign frame_end = EN && (idx_q == 3'd7) && (cnt_q == CNT_LAST);

  // Slot counter and digit index; disabling parks the scan at digit 0, cnt 0
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!EN) begin
      cnt_d = '0;
      idx_d = 3'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Load staging and commit; a load in the frame-end cycle bypasses staging
  always_comb begin
    pend_d     = pend_q;
    pend_dig_d = pend_dig_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    shd_dig_d  = shd_dig_q;
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    commit     = 1'b0;
    if (frame_end) begin
      if (LOAD) begin
        shd_dig_d = DIGITS;
        shd_val_d = VALID;
        shd_dp_d  = DP;
        pend_d    = 1'b0;
        commit    = 1'b1;
      end else if (pend_q) begin
        shd_dig_d = pend_dig_q;
        shd_val_d = pend_val_q;
        shd_dp_d  = pend_dp_q;
        pend_d    = 1'b0;
        commit    = 1'b1;
      end
    end else if (LOAD) begin
      // Latest load wins; only the eventual commit produces an ACK
      pend_dig_d = DIGITS;
      pend_val_d = VALID;
      pend_dp_d  = DP;
      pend_d     = 1'b1;
    end else if (!EN && pend_q) begin
      // Display is dark while disabled, so there is no frame to protect
      shd_dig_d = pend_dig_q;
      shd_val_d = pend_val_q;
      shd_dp_d  = pend_dp_q;
      pend_d    = 1'b0;
      commit    = 1'b1;
    end
  end

  // Split the next shadow into per-digit codes and build the digit one-hot
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign code_arr[gi]     = shd_dig_d[4*gi +: 4];
      assign digit_onehot[gi] = (idx_d == 3'(gi));
    end
  endgenerate

  assign sel_code  = code_arr[idx_d];
  assign sel_valid = shd_val_d[idx_d];
  assign sel_dp    = shd_dp_d[idx_d];

  // Next display drive from next cnt/idx/shadow; disabled scan sits at cnt 0,
  // which always falls in the blank phase
  always_comb begin
    blank_d = (cnt_d < CNT_BLANK) || !sel_valid;
    com_d   = 8'hFF;
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    if (!blank_d) begin
      com_d = ~digit_onehot;
      seg_d = decode_hex(sel_code);
      dp_d  = sel_dp;
    end
    frame_d = (idx_d == 3'd7) && (cnt_d == CNT_LAST);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      pend_q     <= 1'b0;
      pend_dig_q <= 32'h0;
      pend_val_q <= 8'h00;
      pend_dp_q  <= 8'h00;
      shd_dig_q  <= 32'h0;
      shd_val_q  <= 8'h00;
      shd_dp_q   <= 8'h00;
      com_q      <= 8'hFF;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shd_dig_q  <= shd_dig_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      com_q      <= com_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      ack_q      <= commit;
      frame_q    <= frame_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp    = dp_q;
  assign COM   = com_q;
  assign ACK   = ack_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed stimulus with a cycle-keyed scoreboard for seg_scan.
module tb_seg_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        CLK = 1'b0;
  logic        RSTN, EN, LOAD;
  logic [31:0] DIGITS;
  logic [7:0]  VALID, DP;
  logic        a, b, c, d, e, f, g, dp;
  logic [7:0]  COM;
  logic        ACK, FRAME;

  seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .LOAD(LOAD),
    .DIGITS(DIGITS), .VALID(VALID), .DP(DP),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .COM(COM), .ACK(ACK), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         c;
    string      nm;
    logic [7:0] com;
    logic [6:0] seg;
    logic       dpv;
  } exp_t;

  exp_t exp_q[$];
  int   ack_exp[$];
  int   frame_exp[$];

  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  logic [6:0] mon_seg;
  assign mon_seg = {a, b, c, d, e, f, g};

  function automatic logic [6:0] segs(input string s);
    logic [6:0] r;
    r = 7'h00;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": r[6] = 1'b1;
        "b": r[5] = 1'b1;
        "c": r[4] = 1'b1;
        "d": r[3] = 1'b1;
        "e": r[2] = 1'b1;
        "f": r[1] = 1'b1;
        "g": r[0] = 1'b1;
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] com_of(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  task automatic push(input int cc, input string nm, input logic [7:0] com,
                      input string sg, input logic dpv);
    exp_t x;
    x.c   = cc;
    x.nm  = nm;
    x.com = com;
    x.seg = segs(sg);
    x.dpv = dpv;
    exp_q.push_back(x);
  endtask

  task automatic push_dark(input int cc, input string nm);
    push(cc, nm, 8'hFF, "", 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic goto(input int cc);
    while (cyc < cc) tick();
  endtask

  // Monitor: compare outputs against whatever the stimulus queued for this cycle
  always @(negedge CLK) begin
    if (cyc >= 1) begin
      n_checks++;
      if ($countones(~COM) > 1) begin
        n_errors++;
        $display("FAIL com_onehot cyc=%0d COM=%h required at most one low bit", cyc, COM);
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].c == cyc) begin
          n_checks++;
          if (COM !== exp_q[i].com || mon_seg !== exp_q[i].seg || dp !== exp_q[i].dpv) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got COM=%h seg=%b dp=%b required COM=%h seg=%b dp=%b",
                     exp_q[i].nm, cyc, COM, mon_seg, dp, exp_q[i].com, exp_q[i].seg, exp_q[i].dpv);
          end
          exp_q.delete(i);
        end else if (exp_q[i].c < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", exp_q[i].nm, exp_q[i].c, cyc);
          exp_q.delete(i);
        end
      end
      if (ACK === 1'b1) begin
        n_checks++;
        if (ack_exp.size() == 0) begin
          n_errors++;
          $display("FAIL ack_unexpected cyc=%0d got ACK=1 required ACK=0", cyc);
        end else begin
          if (ack_exp[0] != cyc) begin
            n_errors++;
            $display("FAIL ack_cycle got ACK at cyc=%0d required cyc=%0d", cyc, ack_exp[0]);
          end
          void'(ack_exp.pop_front());
        end
      end
      if (FRAME === 1'b1) begin
        n_checks++;
        if (frame_exp.size() == 0) begin
          n_errors++;
          $display("FAIL frame_unexpected cyc=%0d got FRAME=1 required FRAME=0", cyc);
        end else begin
          if (frame_exp[0] != cyc) begin
            n_errors++;
            $display("FAIL frame_cycle got FRAME at cyc=%0d required cyc=%0d", cyc, frame_exp[0]);
          end
          void'(frame_exp.pop_front());
        end
      end
    end
  end

  int         s0, f2, f3, f4, f5, f6, s2, f7, r0;
  logic [7:0] m_val, m_dp;

  // Stimulus: directed sequence, expectations queued ahead of each cycle
  initial begin
    RSTN = 1'b0; EN = 1'b0; LOAD = 1'b0;
    DIGITS = 32'h0; VALID = 8'h00; DP = 8'h00;
    m_val = 8'hA5; m_dp = 8'h81;

    // Reset state
    goto(1);
    push_dark(1, "rst_c1"); push_dark(2, "rst_c2"); push_dark(3, "rst_c3");
    goto(3);
    RSTN = 1'b1;

    // Load while disabled: ACK two cycles later, display stays dark
    goto(4);
    LOAD = 1'b1; DIGITS = 32'h76543210; VALID = 8'hFF; DP = 8'h01;
    ack_exp.push_back(6);
    push_dark(4, "en0_c4");
    goto(5);
    LOAD = 1'b0;
    push_dark(5, "en0_c5"); push_dark(6, "en0_ack_cycle");

    // Full scan starting at digit 0 with two blank cycles
    goto(7);
    EN = 1'b1;
    s0 = 7;
    frame_exp.push_back(s0 + 63);
    for (int k = 0; k < 8; k++) begin
      push_dark(s0 + 8*k, $sformatf("scan_blank0_d%0d", k));
      push_dark(s0 + 8*k + 1, $sformatf("scan_blank1_d%0d", k));
      push(s0 + 8*k + 2, $sformatf("scan_first_d%0d", k), com_of(k), glyph[k], k == 0);
      push(s0 + 8*k + 7, $sformatf("scan_last_d%0d", k), com_of(k), glyph[k], k == 0);
    end

    // Deferred load issued during digit 3
    f2 = s0 + 64;
    goto(f2);
    frame_exp.push_back(f2 + 63);
    push(f2 + 2, "defer_old_d0", 8'hFE, "abcdef", 1'b1);
    push(f2 + 34, "defer_old_d4", 8'hEF, "bcfg", 1'b0);
    push(f2 + 63, "defer_old_d7", 8'h7F, "abc", 1'b0);
    goto(f2 + 26);
    LOAD = 1'b1; DIGITS = 32'hFFFFFFFF; VALID = 8'hFF; DP = 8'h00;
    ack_exp.push_back(f2 + 64);
    goto(f2 + 27);
    LOAD = 1'b0;

    // Load collision: two loads in one frame, single ACK, latest wins
    f3 = f2 + 64;
    goto(f3);
    frame_exp.push_back(f3 + 63);
    push_dark(f3, "defer_new_blank");
    push(f3 + 2, "defer_new_d0", 8'hFE, "aefg", 1'b0);
    push(f3 + 50, "defer_new_d6", 8'hBF, "aefg", 1'b0);
    goto(f3 + 10);
    LOAD = 1'b1; DIGITS = 32'h11111111;
    goto(f3 + 11);
    LOAD = 1'b0;
    goto(f3 + 40);
    LOAD = 1'b1; DIGITS = 32'h22222222;
    ack_exp.push_back(f3 + 64);
    goto(f3 + 41);
    LOAD = 1'b0;

    f4 = f3 + 64;
    goto(f4);
    frame_exp.push_back(f4 + 63);
    for (int k = 0; k < 8; k++) begin
      push_dark(f4 + 8*k + 1, $sformatf("coll_blank_d%0d", k));
      push(f4 + 8*k + 4, $sformatf("coll_two_d%0d", k), com_of(k), "abdeg", 1'b0);
    end

    // Load in the frame-end cycle goes straight to the shadow
    goto(f4 + 63);
    LOAD = 1'b1; DIGITS = 32'h89ABCDEF; VALID = m_val; DP = m_dp;
    ack_exp.push_back(f4 + 64);
    goto(f4 + 64);
    LOAD = 1'b0;

    // Masking: digits 1,3,4,6 dark
    f5 = f4 + 64;
    frame_exp.push_back(f5 + 63);
    for (int k = 0; k < 8; k++) begin
      push_dark(f5 + 8*k, $sformatf("mask_blank_d%0d", k));
      if (m_val[k]) begin
        push(f5 + 8*k + 3, $sformatf("mask_lit_d%0d", k), com_of(k), glyph[15-k], m_dp[k]);
        push(f5 + 8*k + 7, $sformatf("mask_lit_end_d%0d", k), com_of(k), glyph[15-k], m_dp[k]);
      end else begin
        push_dark(f5 + 8*k + 3, $sformatf("mask_dark_d%0d", k));
        push_dark(f5 + 8*k + 7, $sformatf("mask_dark_end_d%0d", k));
      end
    end

    // Enable drop mid-slot of digit 5, load while disabled, restart
    f6 = f5 + 64;
    goto(f6);
    push(f6 + 42, "en_d5_lit", 8'hDF, "abcefg", 1'b0);
    goto(f6 + 43);
    EN = 1'b0;
    push_dark(f6 + 44, "en_off_c1");
    push_dark(f6 + 45, "en_off_c2");
    goto(f6 + 46);
    LOAD = 1'b1; DIGITS = 32'h3210FEDC; VALID = 8'hFF; DP = 8'h00;
    ack_exp.push_back(f6 + 48);
    goto(f6 + 47);
    LOAD = 1'b0;
    push_dark(f6 + 47, "en_off_c4");
    push_dark(f6 + 48, "en_off_ack");
    goto(f6 + 50);
    EN = 1'b1;
    s2 = f6 + 50;
    frame_exp.push_back(s2 + 63);
    push_dark(s2, "restart_blank0");
    push_dark(s2 + 1, "restart_blank1");
    push(s2 + 2, "restart_d0", 8'hFE, "adef", 1'b0);
    push(s2 + 10, "restart_d1", 8'hFD, "bcdeg", 1'b0);
    push(s2 + 34, "restart_d4", 8'hEF, "abcdef", 1'b0);

    // Reset mid-scan with a load pending: no ACK, shadow cleared
    f7 = s2 + 64;
    goto(f7 + 20);
    LOAD = 1'b1; DIGITS = 32'h99999999; VALID = 8'hFF; DP = 8'hFF;
    goto(f7 + 21);
    LOAD = 1'b0;
    push(f7 + 21, "prerst_d2", 8'hFB, "adefg", 1'b0);
    goto(f7 + 22);
    RSTN = 1'b0;
    push_dark(f7 + 23, "midrst_c1");
    push_dark(f7 + 24, "midrst_c2");
    push_dark(f7 + 25, "midrst_c3");
    goto(f7 + 25);
    RSTN = 1'b1;
    r0 = f7 + 25;
    frame_exp.push_back(r0 + 63);
    push_dark(r0 + 1, "postrst_blank");
    push_dark(r0 + 2, "postrst_d0_dark");
    push_dark(r0 + 40, "postrst_d5_dark");
    goto(r0 + 72);
    tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    n_checks++;
    if (ack_exp.size() != 0) begin
      n_errors++;
      $display("FAIL ack_missing got %0d outstanding ACKs required 0 (next at cyc=%0d)",
               ack_exp.size(), ack_exp[0]);
    end
    n_checks++;
    if (frame_exp.size() != 0) begin
      n_errors++;
      $display("FAIL frame_missing got %0d outstanding FRAMEs required 0 (next at cyc=%0d)",
               frame_exp.size(), frame_exp[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan controller for the board's 8-digit common-cathode 7-segment display, whose segment lines a..g and dp are shared by all digits. It cycles the active-low digit commons COM[7:0] so that one digit owns the segment bus per slot, and decodes each digit's 4-bit code to hexadecimal glyphs. A blanking interval at each slot start prevents ghosting. A LOAD/ACK handshake double-buffers the display contents so updates land only on frame boundaries, never mid-frame.

## Interface
- DIV, 1000: clock cycles per digit slot; must satisfy DIV >= BLANK+2.
- BLANK, 16: cycles at the start of each slot with all commons off; must satisfy BLANK >= 1.
- CLK  in  1  system clock; all state changes on its rising edge.
- RSTN  in  1  reset; one clock, reset is synchronous and active-low.
- EN  in  1  scan enable; low freezes the scan and blanks the display.
- LOAD  in  1  single-cycle request to capture DIGITS/VALID/DP.
- DIGITS  in  32  digit codes; DIGITS[4k+3:4k] drives digit k.
- VALID  in  8  per-digit enable; a 0 keeps that digit dark.
- DP  in  8  per-digit decimal point.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-high.
- dp  out  1  decimal point, active-high.
- COM  out  8  digit commons, active-low; at most one bit is low at any time.
- ACK  out  1  one-cycle pulse: the pending load is now displayed.
- FRAME  out  1  one-cycle pulse on the last cycle of digit 7's slot.

## Operation
- State:
  - slot counter cnt, range 0..DIV-1.
  - digit index idx, range 0..7.
  - pending registers (digits, valid, dp) and a pend flag.
  - shadow registers (digits, valid, dp), which feed the display.
- Scan:
  - cnt increments each cycle while EN=1.
  - At cnt=DIV-1, cnt wraps to 0 and idx increments.
  - idx wraps from 7 to 0.
- Blank phase (cnt < BLANK): COM=8'hFF and all segments plus dp are 0.
- Drive phase (cnt >= BLANK):
  - COM[idx]=0 if shadow VALID[idx]=1, otherwise COM=8'hFF.
  - Segments show the decoded shadow digit idx. dp shows shadow DP[idx].
  - All segments and dp are 0 when the digit is invalid.
- Decode, listing the lit segments:
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg
  - 4: bcfg; 5: acdfg; 6: acdefg; 7: abc
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg
  - C: adef; d: bcdeg; E: adefg; F: aefg
- Load handshake:
  - LOAD=1 copies DIGITS/VALID/DP into the pending registers and sets pend.
  - A second LOAD before commit overwrites pending. Latest wins, and only one ACK is issued.
  - Commit point (frame end): EN=1, idx=7 and cnt=DIV-1.
  - At the commit point with pend=1: shadow <= pending and pend clears.
  - LOAD in the frame-end cycle itself: that cycle's inputs go straight to shadow and pend stays clear.
  - While EN=0: any pending load commits on the next cycle, since there is no frame to tear.
- EN=0:
  - cnt and idx are forced to 0.
  - COM=8'hFF and all segments and dp are 0.
  - FRAME stays 0.
  - Scanning resumes at digit 0, cnt 0, on the first cycle EN=1.

## Timing
- Outputs are registered, with no skew between COM and the segment lines.
- In any cycle, a..g, dp and COM are a pure function of that cycle's cnt, idx and shadow.
- Frame length is 8*DIV cycles. Each digit's lit time is DIV-BLANK cycles.
- ACK is asserted for exactly 1 cycle, in the cycle after the shadow update. The new data is visible from the slot of digit 0.
- FRAME is high in the cycle where idx=7 and cnt=DIV-1.
- Reset, applied with RSTN low at the clock edge, in any state including mid-slot or with a load pending:
  - cnt=0, idx=0, pend=0.
  - Shadow and pending registers: digits 0, valid 0, dp 0.
  - COM=8'hFF; a..g=0, dp=0.
  - ACK=0, FRAME=0.
- The first cycle after reset release is the first blank cycle of digit 0.

## Test plan
Benches use DIV=8, BLANK=2 unless stated otherwise.
- **Reset:** hold RSTN=0 for 3 cycles mid-scan with a load pending -> COM=FF, segments 0, ACK and FRAME never pulse. After release, digit 0 blank occupies cycles 0-1 and COM=FE first appears in cycle 2 (only if valid).
- **Full scan:** load DIGITS=32'h76543210, VALID=FF, DP=01, EN=1 -> after ACK, each slot k shows COM with only bit k low for 6 cycles. Digit 0 shows abcdef with dp=1; digit 3 shows abcdg. FRAME pulses every 64 cycles.
- **Deferred load:** LOAD with 32'hFFFFFFFF while idx=3 -> old glyphs persist through digit 7. The shadow update happens at the frame end, ACK follows 1 cycle later, and digit 0 of the next frame shows aefg.
- **Load collision:** two LOADs, 32'h11111111 then 32'h22222222, in the same frame -> a single ACK, and the next frame shows 2 (abdeg) on every digit. Separately, LOAD in the FRAME cycle -> ACK on the next cycle and no pend left set.
- **Masking:** VALID=8'b10100101 -> COM stays FF during the slots of digits 1, 3, 4 and 6, with segments 0 there. At every cycle, COM has at most one zero bit.
- **Enable:** drop EN mid-slot of digit 5 -> blanked on the next cycle with cnt/idx reset. A LOAD while EN=0 gives ACK 2 cycles after LOAD. Raising EN restarts at digit 0 with 2 blank cycles.
